// File: rtl/adc_sequencer.sv
// adc_sequencer: multi-channel conversion scheduler for the SAR ADC controller.
// Walks the enabled mux channels: settle (ADC held in reset), convert, capture.
// Captured results are queued with their channel tag in a small FIFO.
// Optional feature macro: ADC_SEQ_WATCHDOG_EN (CONVERT watchdog, sticky timeout).
//
// Result handshake: an entry transfers on a rising clk edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and the head
// entry (out_data/out_channel) stays stable until it has transferred.
module adc_sequencer #(
  parameter int MATRIX_BITS   = 12,
  parameter int NUM_CHANNELS  = 4,
  parameter int CH_BITS       = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int WDOG_CYCLES   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_CHANNELS-1:0]   channel_mask,
  input  logic [3*NUM_CHANNELS-1:0] avg_cfg,
  input  logic                      adc_conv_finished,
  input  logic [MATRIX_BITS-1:0]    adc_result,
  output logic                      adc_rst_n,
  output logic [2:0]                adc_avg_control,
  output logic [CH_BITS-1:0]        mux_sel,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MATRIX_BITS-1:0]    out_data,
  output logic [CH_BITS-1:0]        out_channel,
  output logic                      overflow,
  output logic                      timeout
);

  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SET_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT} state_t;

  state_t                    state, state_next;
  logic [NUM_CHANNELS-1:0]   scan_mask;
  logic [SET_BITS-1:0]       settle_cnt;
  logic                      seen_low;
  logic                      capture;
  logic                      wd_expire;
  logic                      load_ch;
  logic                      relatch;
  logic [CH_BITS-1:0]        new_ch;
  logic [CH_BITS:0]          next_hit;
  logic [CH_BITS:0]          first_hit;
  logic                      adc_rst_n_next;
  logic [CH_BITS-1:0]        mux_next;
  logic [2:0]                avg_next;

  logic [MATRIX_BITS+CH_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]       wr_ptr, rd_ptr;
  logic [PTR_BITS:0]         count;
  logic                      full, pop, do_push;

  // Lowest set bit of m at index lo or above; returns {found, index}.
  function automatic logic [CH_BITS:0] find_from(input logic [NUM_CHANNELS-1:0] m,
                                                 input int lo);
    logic [CH_BITS:0] r;
    r = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, CH_BITS'(i)};
    end
    return r;
  endfunction

  assign capture   = (state == CONVERT) && adc_conv_finished && seen_low;
  assign next_hit  = find_from(scan_mask, int'(mux_sel) + 1);
  assign first_hit = find_from(channel_mask, 0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic, including which channel (if any) to load into SETTLE.
  always_comb begin
    state_next = state;
    load_ch    = 1'b0;
    relatch    = 1'b0;
    new_ch     = '0;
    case (state)
      IDLE: begin
        if (start && first_hit[CH_BITS]) begin
          state_next = SETTLE;
          load_ch    = 1'b1;
          relatch    = 1'b1;
          new_ch     = first_hit[CH_BITS-1:0];
        end
      end
      SETTLE: begin
        if (settle_cnt == SET_BITS'(SETTLE_CYCLES - 1)) state_next = CONVERT;
      end
      CONVERT: begin
        if (capture) begin
          if (next_hit[CH_BITS]) begin
            state_next = SETTLE;
            load_ch    = 1'b1;
            new_ch     = next_hit[CH_BITS-1:0];
          end else if (continuous && first_hit[CH_BITS]) begin
            state_next = SETTLE;
            load_ch    = 1'b1;
            relatch    = 1'b1;
            new_ch     = first_hit[CH_BITS-1:0];
          end else begin
            state_next = IDLE;
          end
        end else if (wd_expire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered ADC/mux controls, plus busy.
  always_comb begin
    adc_rst_n_next = (state_next == CONVERT);
    mux_next       = mux_sel;
    avg_next       = adc_avg_control;
    busy           = (state != IDLE);
    if (load_ch) begin
      mux_next = new_ch;
      avg_next = avg_cfg[3*int'(new_ch) +: 3];
    end
  end

  // Registered ADC reset, averaging code and mux select.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_rst_n       <= 1'b0;
      mux_sel         <= '0;
      adc_avg_control <= '0;
    end else begin
      adc_rst_n       <= adc_rst_n_next;
      mux_sel         <= mux_next;
      adc_avg_control <= avg_next;
    end
  end

  // Scan bookkeeping: mask latch, settle counter, seen_low, sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_mask  <= '0;
      settle_cnt <= '0;
      seen_low   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (relatch) scan_mask <= channel_mask;
      settle_cnt <= (state == SETTLE && state_next == SETTLE) ? settle_cnt + 1'b1 : '0;
      seen_low   <= (state == CONVERT && state_next == CONVERT) &&
                    (seen_low || !adc_conv_finished);
      if (state == IDLE && load_ch)  overflow <= 1'b0;
      else if (capture && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef ADC_SEQ_WATCHDOG_EN
  localparam int WD_BITS = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;
  logic [WD_BITS-1:0] wd_cnt;

  assign wd_expire = (state == CONVERT) && !capture &&
                     (wd_cnt == WD_BITS'(WDOG_CYCLES - 1));

  // Watchdog counter runs only while waiting for a capture in CONVERT.
  always_ff @(posedge clk) begin
    if (rst || state != CONVERT || capture || wd_expire) wd_cnt <= '0;
    else                                                 wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky timeout, cleared when a new scan starts.
  always_ff @(posedge clk) begin
    if (rst)                        timeout <= 1'b0;
    else if (state == IDLE && load_ch) timeout <= 1'b0;
    else if (wd_expire)             timeout <= 1'b1;
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
  // The watchdog limit only matters when the watchdog is built in.
  if (WDOG_CYCLES < 1) begin : g_wdog_limit_unused
  end
`endif

  assign full      = (count == (PTR_BITS+1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign do_push   = capture && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr][MATRIX_BITS-1:0] : '0;
  assign out_channel = out_valid ? mem[rd_ptr][MATRIX_BITS+CH_BITS-1:MATRIX_BITS] : '0;

  // FIFO pointers and occupancy; contents are discarded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {mux_sel, adc_result};
  end

endmodule
